// File: rtl/wisc_ctrl_pkg.sv
// Shared types for the WISC-15 control path: opcodes, ALU command
// encodings and the per-instruction control bundle carried into EX.
package wisc_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_PADDSB = 4'b0001,
        OP_SUB    = 4'b0010,
        OP_NAND   = 4'b0011,
        OP_XOR    = 4'b0100,
        OP_SLL    = 4'b0101,
        OP_SRL    = 4'b0110,
        OP_SRA    = 4'b0111,
        OP_LW     = 4'b1000,
        OP_SW     = 4'b1001,
        OP_LHB    = 4'b1010,
        OP_LLB    = 4'b1011,
        OP_B      = 4'b1100,
        OP_CALL   = 4'b1101,
        OP_RET    = 4'b1110,
        OP_HLT    = 4'b1111
    } opcode_e;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_PADDSB = 4'b0010;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_NAND   = 4'b1000;
    localparam logic [3:0] ALU_SLL    = 4'b1100;
    localparam logic [3:0] ALU_SRL    = 4'b1110;
    localparam logic [3:0] ALU_SRA    = 4'b1111;

    typedef struct packed {
        logic [3:0] alu_cmd;
        logic       reg_wrt;
        logic       mem_to_reg;
        logic       mem_wrt;
        logic       branch;
        logic       set_over;
        logic       set_zero;
        logic       is_lw;
        logic       is_hlt;
        logic       uses_src1;
        logic       uses_src2;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    // Halt sequencing: HLT enters EX (DRAINING), then the core stops.
    typedef enum logic [1:0] {
        HS_RUN      = 2'b00,
        HS_DRAINING = 2'b01,
        HS_HALTED   = 2'b10
    } halt_state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decoder producing the control bundle.
module ctrl_decode
    import wisc_ctrl_pkg::*;
(
    input  logic [3:0]   opcode,
    output ctrl_bundle_t bundle
);

    // Map each opcode to its controls; anything not set stays zero.
    always_comb begin
        bundle = CTRL_BUBBLE;
        case (opcode)
            OP_ADD:    begin bundle.alu_cmd = ALU_ADD;    bundle.reg_wrt = 1'b1;
                             bundle.set_over = 1'b1;      bundle.set_zero = 1'b1; end
            OP_PADDSB: begin bundle.alu_cmd = ALU_PADDSB; bundle.reg_wrt = 1'b1; end
            OP_SUB:    begin bundle.alu_cmd = ALU_SUB;    bundle.reg_wrt = 1'b1;
                             bundle.set_over = 1'b1;      bundle.set_zero = 1'b1; end
            OP_NAND:   begin bundle.alu_cmd = ALU_NAND;   bundle.reg_wrt = 1'b1; bundle.set_zero = 1'b1; end
            OP_XOR:    begin bundle.alu_cmd = ALU_XOR;    bundle.reg_wrt = 1'b1; bundle.set_zero = 1'b1; end
            OP_SLL:    begin bundle.alu_cmd = ALU_SLL;    bundle.reg_wrt = 1'b1; bundle.set_zero = 1'b1; end
            OP_SRL:    begin bundle.alu_cmd = ALU_SRL;    bundle.reg_wrt = 1'b1; bundle.set_zero = 1'b1; end
            OP_SRA:    begin bundle.alu_cmd = ALU_SRA;    bundle.reg_wrt = 1'b1; bundle.set_zero = 1'b1; end
            OP_LW:     begin bundle.reg_wrt = 1'b1; bundle.mem_to_reg = 1'b1; bundle.is_lw = 1'b1; end
            OP_SW:     bundle.mem_wrt = 1'b1;
            OP_LHB:    bundle.reg_wrt = 1'b1;
            OP_LLB:    bundle.reg_wrt = 1'b1;
            OP_B:      bundle.branch = 1'b1;
            OP_CALL:   begin bundle.reg_wrt = 1'b1; bundle.branch = 1'b1; end
            OP_RET:    bundle.branch = 1'b1;
            OP_HLT:    bundle.is_hlt = 1'b1;
            default:   bundle = CTRL_BUBBLE;
        endcase
        // ALU ops read both sources; LW/RET read src1 only; SW reads both.
        bundle.uses_src1 = (opcode[3] == 1'b0) || (opcode == OP_LW) ||
                           (opcode == OP_SW) || (opcode == OP_RET);
        bundle.uses_src2 = (opcode[3] == 1'b0) || (opcode == OP_SW);
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID-stage control: decode, load-use hazard stall, branch squash,
// ID/EX control register and halt sequencing for the WISC-15 pipeline.
//
// Handshake: id_ready=1 means the instruction presented in ID (when
// id_valid=1) is consumed at the coming rising edge, either by moving
// into ID/EX or by being squashed under a taken branch; id_ready=0
// means IF/ID must hold its contents.
module ctrl_pipe_unit
    import wisc_ctrl_pkg::*;
#(
    parameter int REG_AW       = 4,
    parameter int ALU_CMD_W    = 4,
    parameter int ZERO_REG_HAZ = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [3:0]           id_opcode,
    input  logic [REG_AW-1:0]    id_src1,
    input  logic [REG_AW-1:0]    id_src2,
    input  logic [REG_AW-1:0]    id_dst,
    input  logic                 ex_branch_taken,
    output logic                 id_ready,
    output logic                 ex_valid,
    output logic [ALU_CMD_W-1:0] ex_alu_cmd,
    output logic                 ex_reg_wrt,
    output logic                 ex_mem_to_reg,
    output logic                 ex_mem_wrt,
    output logic                 ex_branch,
    output logic                 ex_set_over,
    output logic                 ex_set_zero,
    output logic [REG_AW-1:0]    ex_dst,
    output logic                 halted
);

    logic [1:0]        rst_sync_q;
    logic              rst_int_n;
    ctrl_bundle_t      id_ctrl;
    ctrl_bundle_t      ex_ctrl_q;
    ctrl_bundle_t      ex_ctrl_d;
    logic              ex_valid_q;
    logic              ex_valid_d;
    logic [REG_AW-1:0] ex_dst_q;
    logic [REG_AW-1:0] ex_dst_d;
    logic              dst_can_haz;
    logic              stall;
    logic              ex_holds_hlt;
    logic              hlt_issue;
    halt_state_e       halt_state_q;
    halt_state_e       halt_state_d;
    logic              unused_ex_bits;

    // Reset asserts immediately and releases two clean edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    ctrl_decode u_decode (
        .opcode (id_opcode),
        .bundle (id_ctrl)
    );

    // R0 is hard-wired zero unless hazards on it are explicitly wanted.
    assign dst_can_haz  = (ZERO_REG_HAZ != 0) || (ex_dst_q != '0);
    assign stall        = id_valid && ex_valid_q && ex_ctrl_q.is_lw && dst_can_haz &&
                          ((id_ctrl.uses_src1 && (id_src1 == ex_dst_q)) ||
                           (id_ctrl.uses_src2 && (id_src2 == ex_dst_q)));
    assign ex_holds_hlt = ex_valid_q && ex_ctrl_q.is_hlt;

    // Choose what enters ID/EX: squash, halt block, stall bubble or decode.
    always_comb begin
        ex_ctrl_d  = CTRL_BUBBLE;
        ex_valid_d = 1'b0;
        ex_dst_d   = '0;
        id_ready   = 1'b0;
        hlt_issue  = 1'b0;
        if (ex_branch_taken) begin
            id_ready = 1'b1;
        end else if (halted || ex_holds_hlt) begin
            id_ready = 1'b0;
        end else if (stall) begin
            id_ready = 1'b0;
        end else begin
            id_ready = 1'b1;
            if (id_valid) begin
                ex_ctrl_d  = id_ctrl;
                ex_valid_d = 1'b1;
                ex_dst_d   = id_dst;
                hlt_issue  = id_ctrl.is_hlt;
            end
        end
    end

    // ID/EX boundary register.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ex_ctrl_q  <= CTRL_BUBBLE;
            ex_valid_q <= 1'b0;
            ex_dst_q   <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_valid_q <= ex_valid_d;
            ex_dst_q   <= ex_dst_d;
        end
    end

    // Halt state register.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) halt_state_q <= HS_RUN;
        else            halt_state_q <= halt_state_d;
    end

    // Halt next state: only a HLT actually written into ID/EX starts a drain.
    always_comb begin
        halt_state_d = halt_state_q;
        case (halt_state_q)
            HS_RUN:      if (hlt_issue) halt_state_d = HS_DRAINING;
            HS_DRAINING: halt_state_d = HS_HALTED;
            HS_HALTED:   halt_state_d = HS_HALTED;
            default:     halt_state_d = HS_RUN;
        endcase
    end

    assign halted         = (halt_state_q == HS_HALTED);
    assign ex_valid       = ex_valid_q;
    assign ex_alu_cmd     = ALU_CMD_W'(ex_ctrl_q.alu_cmd);
    assign ex_reg_wrt     = ex_ctrl_q.reg_wrt;
    assign ex_mem_to_reg  = ex_ctrl_q.mem_to_reg;
    assign ex_mem_wrt     = ex_ctrl_q.mem_wrt;
    assign ex_branch      = ex_ctrl_q.branch;
    assign ex_set_over    = ex_ctrl_q.set_over;
    assign ex_set_zero    = ex_ctrl_q.set_zero;
    assign ex_dst         = ex_dst_q;
    assign unused_ex_bits = ex_ctrl_q.uses_src1 ^ ex_ctrl_q.uses_src2;

endmodule
